mmio_timer: RTL and testbench
=============================

MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameters: none; register map and encodings are fixed constants.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (reset=0 resets immediately; release synchronous to clk).
REQ-004 sel  input  1  CPU data-bus select for this device, valid for the current cycle.
REQ-005 we  input  1  write strobe, qualified by sel.
REQ-006 addr  input  2  word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-007 wdata  input  32  write data.
REQ-008 rdata  output  32  combinational read data for addr, independent of sel.
REQ-009 irq  output  1  interrupt request to CPU, level, registered.

Function
REQ-010 CTRL bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 10/11 treated as 00), bit3 IM (irq mask); read returns {28'b0, CTRL[3:0]}.
REQ-011 PRESET is 32-bit read/write; COUNT is 32-bit read-only, writes ignored; reserved offset reads 0, writes ignored.
REQ-012 Register write occurs at the clk edge where sel=1 and we=1; a read in the same cycle returns the old value.
REQ-013 FSM states IDLE, LOAD, CNT, INT; single state advance per cycle.
REQ-014 IDLE: if EN=1 -> LOAD; else stay; COUNT holds.
REQ-015 LOAD: COUNT<=PRESET; -> CNT.
REQ-016 CNT: if EN=0 -> IDLE with COUNT held; else if COUNT<=1 then COUNT<=0 and -> INT; else COUNT<=COUNT-1.
REQ-017 INT: pend<=1; MODE 00 -> IDLE and EN<=0; MODE 01 -> LOAD.
REQ-018 irq = pend AND IM, registered; IM change reflects on irq next cycle.
REQ-019 MODE 00: pend stays 1 until any CTRL write, which clears it.
REQ-020 MODE 01: pend is 1 for exactly the one cycle following INT (auto-cleared on LOAD); period = PRESET+2 cycles.
REQ-021 Latency: CTRL write EN=1 at edge E0 with PRESET=P>=1 -> COUNT=P after E2, irq high after E(P+2).
REQ-022 PRESET=0 behaves as PRESET=1 (INT reached one cycle after LOAD).
REQ-023 PRESET write while counting takes effect only at the next LOAD.
REQ-024 CTRL write coinciding with INT's hardware EN clear: software write value wins for all CTRL bits; FSM transition still follows REQ-017.
REQ-025 EN cleared mid-count, then set again -> reload from PRESET (IDLE->LOAD), no resume.
REQ-026 COUNT never wraps below 0.

Reset
REQ-027 On reset=0: CTRL=0, PRESET=0, COUNT=0, pend=0, irq=0, state=IDLE, regardless of current state or bus activity.
REQ-028 Reset asserted mid-count aborts immediately; no irq is generated after release until EN is written again.

Structure
REQ-029 Shared package holds address offsets, MODE encodings, CTRL bit positions, FSM state encodings.
REQ-030 Single module, no sub-module; a separate down-counter submodule is not warranted.

Verification
REQ-031 Reset release; read all offsets -> rdata=0 for each; irq=0.
REQ-032 PRESET=5, CTRL=0x9 (EN,IM,one-shot) -> COUNT reads 5,4,3,2,1,0; irq rises 7 cycles after CTRL write edge; CTRL reads 0x8; CTRL write 0x8 -> irq falls next cycle.
REQ-033 PRESET=3, CTRL=0xB (auto-reload) -> irq 1-cycle pulse every 5 cycles for 4 periods; EN stays 1.
REQ-034 Counting from PRESET=10, write CTRL=0 at COUNT=6 -> COUNT holds 6, no irq; rewrite CTRL=0x9 -> COUNT reloads 10.
REQ-035 PRESET=0 and CTRL=0x1 (IM=0) -> pend set, irq stays 0; then CTRL=0x8 -> irq stays 0 (pend cleared by the write).
REQ-036 Assert reset at COUNT=2 of a 4-count run -> all registers 0 immediately, irq never asserts; write to COUNT and offset 3 -> readback unchanged/0.

Source files
------------

// File: rtl/mmio_timer_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register
// offsets, CTRL bit positions, MODE encodings and FSM state encodings.
package mmio_timer_pkg;

   // Word offsets on the CPU data bus
   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_RSVD   = 2'd3;

   // CTRL register layout: {IM, MODE[1:0], EN}
   localparam int CTRL_W        = 4;
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;

   // MODE encodings; 2'b10 and 2'b11 behave as one-shot
   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'b00,
      MODE_RELOAD  = 2'b01
   } mode_e;

   // Counter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   // Only the exact auto-reload code reloads; every other code is one-shot.
   function automatic logic is_reload(input logic [1:0] mode);
      return (mode == MODE_RELOAD);
   endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// CPU data-bus port of the timer: select/strobe/offset/data in, combinational
// read data and level interrupt out.
interface mmio_timer_if;

   logic        sel;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   modport master (output sel, output we, output addr, output wdata,
                   input  rdata, input irq);

   modport slave  (input  sel, input we, input addr, input wdata,
                   output rdata, output irq);

endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Registers: CTRL (EN, MODE, IM), PRESET (reload value), COUNT (read-only).
// A one-shot expiry leaves a pending flag that only a CTRL write clears;
// an auto-reload expiry pends for the single INT cycle before reloading.
module mmio_timer
   import mmio_timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   mmio_timer_if.slave bus
);

   logic [CTRL_W-1:0] r_ctrl;
   logic [31:0]       r_preset;
   logic [31:0]       r_count;
   logic              r_pend;
   logic              r_irq;
   state_e            r_state;

   logic              w_wr_ctrl;
   logic              w_wr_preset;
   logic              w_en;
   logic              w_reload;
   logic              w_expire;
   logic              w_int_reload;
   logic              w_int_oneshot;
   logic [CTRL_W-1:0] w_ctrl_next;
   logic              w_pend_next;
   logic [31:0]       w_rdata;

   // Bus write decode; COUNT and the reserved offset have no write path.
   assign w_wr_ctrl   = bus.sel & bus.we & (bus.addr == ADDR_CTRL);
   assign w_wr_preset = bus.sel & bus.we & (bus.addr == ADDR_PRESET);

   assign w_en     = r_ctrl[CTRL_EN_BIT];
   assign w_reload = is_reload(r_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB]);

   // Expiry happens on the CNT cycle that sees COUNT<=1 with EN still set,
   // so PRESET=0 expires exactly like PRESET=1 and COUNT never wraps.
   assign w_expire      = (r_state == ST_CNT) & w_en & (r_count <= 32'd1);
   assign w_int_reload  = (r_state == ST_INT) & w_reload;
   assign w_int_oneshot = (r_state == ST_INT) & ~w_reload;

   // Next CTRL: one-shot expiry drops EN, but a coincident software write wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path
      // can leave it unassigned and infer a latch.
      w_ctrl_next = r_ctrl;
      if (w_int_oneshot) begin
         w_ctrl_next[CTRL_EN_BIT] = 1'b0;
      end
      if (w_wr_ctrl) begin
         w_ctrl_next = bus.wdata[CTRL_W-1:0];
      end
   end

   // Next pending flag: a new expiry takes priority over any clear.
   always_comb begin
      w_pend_next = r_pend;
      if (w_wr_ctrl || w_int_reload) begin
         w_pend_next = 1'b0;
      end
      if (w_expire) begin
         w_pend_next = 1'b1;
      end
   end

   // Software-visible registers, pending flag and the registered irq.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ctrl   <= '0;
         r_preset <= '0;
         r_pend   <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples pre-edge values regardless of statement order.
         r_ctrl <= w_ctrl_next;
         if (w_wr_preset) begin
            r_preset <= bus.wdata;
         end
         r_pend <= w_pend_next;
         // irq mirrors pend&IM as they will stand after this edge
         r_irq  <= w_pend_next & w_ctrl_next[CTRL_IM_BIT];
      end
   end

   // Counter FSM: IDLE -> LOAD -> CNT ... -> INT -> (LOAD | IDLE).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_en) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_count <= r_preset;
               r_state <= ST_CNT;
            end
            ST_CNT: begin
               if (!w_en) begin
                  r_state <= ST_IDLE;
               end else if (r_count <= 32'd1) begin
                  r_count <= '0;
                  r_state <= ST_INT;
               end else begin
                  r_count <= r_count - 32'd1;
               end
            end
            ST_INT: begin
               r_state <= w_reload ? ST_LOAD : ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Combinational read mux on addr alone; sel does not gate it.
   always_comb begin
      w_rdata = '0;
      case (bus.addr)
         ADDR_CTRL:   w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
         ADDR_PRESET: w_rdata = r_preset;
         ADDR_COUNT:  w_rdata = r_count;
         default:     w_rdata = '0;
      endcase
   end

   assign bus.rdata = w_rdata;
   assign bus.irq   = r_irq;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: directed scenarios plus a randomized bus phase, all
// compared against a timeline model that tracks the position inside the
// current timer period rather than a state register.
module tb_mmio_timer;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   mmio_timer_if bus();

   mmio_timer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: m_armed says a period is running, m_pos is the cycle
   // index in it (0 = load cycle, 1..pe = counting, pe+1 = expiry cycle).
   logic [3:0]  m_ctrl    = '0;
   logic [31:0] m_preset  = '0;
   logic [31:0] m_count   = '0;
   logic [31:0] m_pl      = '0;
   logic        m_pend    = 1'b0;
   logic        m_irq     = 1'b0;
   logic        m_armed   = 1'b0;
   int          m_pos     = 0;

   task automatic model_reset();
      m_ctrl = '0; m_preset = '0; m_count = '0; m_pl = '0;
      m_pend = 1'b0; m_irq = 1'b0; m_armed = 1'b0; m_pos = 0;
   endtask

   // One clock edge of the model, using the bus inputs present at the edge.
   task automatic model_step();
      logic wr_ctrl, wr_pre, en, rel, fired, drop_en;
      int   pe;
      wr_ctrl = bus.sel && bus.we && (bus.addr == 2'd0);
      wr_pre  = bus.sel && bus.we && (bus.addr == 2'd1);
      en      = m_ctrl[0];
      rel     = (m_ctrl[2:1] == 2'b01);
      pe      = (m_pl == 32'd0) ? 1 : int'(m_pl);
      fired   = 1'b0;
      drop_en = 1'b0;
      if (!m_armed) begin
         if (en) begin m_armed = 1'b1; m_pos = 0; end
      end else if (m_pos == 0) begin
         m_pl = m_preset; m_count = m_preset; m_pos = 1;
      end else if (m_pos <= pe) begin
         if (!en) m_armed = 1'b0;
         else if (m_pos == pe) begin m_count = 0; m_pos = pe + 1; fired = 1'b1; end
         else begin m_count = m_pl - 32'(m_pos); m_pos++; end
      end else begin
         if (rel) begin m_pos = 0; m_pend = 1'b0; end
         else begin m_armed = 1'b0; drop_en = 1'b1; end
      end
      if (wr_ctrl) m_pend = 1'b0;
      if (fired)   m_pend = 1'b1;
      if (drop_en) m_ctrl[0] = 1'b0;
      if (wr_ctrl) m_ctrl = bus.wdata[3:0];
      if (wr_pre)  m_preset = bus.wdata;
      m_irq = m_pend & m_ctrl[3];
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         2'd0:    return {28'b0, m_ctrl};
         2'd1:    return m_preset;
         2'd2:    return m_count;
         default: return 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one edge, step the model, then compare irq and the current read.
   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check({tag, " irq"}, {31'b0, bus.irq}, {31'b0, m_irq});
      check({tag, " rdata"}, bus.rdata, m_read(bus.addr));
   endtask

   task automatic drive(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
      bus.sel = s; bus.we = w; bus.addr = a; bus.wdata = d;
   endtask

   // Single-cycle register write, then park the bus reading COUNT.
   task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
      drive(1'b1, 1'b1, a, d);
      tick(tag);
      drive(1'b0, 1'b0, 2'd2, 32'd0);
   endtask

   task automatic rd_now(input logic [1:0] a, input logic [31:0] exp, input string tag);
      bus.addr = a;
      #1;
      check(tag, bus.rdata, exp);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      drive(1'b0, 1'b0, 2'd0, 32'd0);
      reset = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      tick("post_reset");

      // Reset state: every offset reads zero, no interrupt
      for (int a = 0; a < 4; a++) rd_now(2'(a), 32'd0, "reset_read");
      check("reset_irq", {31'b0, bus.irq}, 32'd0);

      // One-shot, PRESET=5: COUNT 5..0 after E2..E7, irq from E7
      wr(2'd1, 32'd5, "os_pre");
      wr(2'd0, 32'h9, "os_ctrl");
      for (int k = 1; k <= 9; k++) begin
         tick("os_run");
         if (k >= 2 && k <= 7) check("os_count", bus.rdata, 32'(7 - k));
         check("os_irq", {31'b0, bus.irq}, (k >= 7) ? 32'd1 : 32'd0);
      end
      rd_now(2'd0, 32'h8, "os_ctrl_after");
      wr(2'd0, 32'h8, "os_ack");
      check("os_irq_cleared", {31'b0, bus.irq}, 32'd0);

      // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles, EN kept
      wr(2'd1, 32'd3, "ar_pre");
      wr(2'd0, 32'hB, "ar_ctrl");
      for (int k = 1; k <= 21; k++) begin
         tick("ar_run");
         check("ar_irq", {31'b0, bus.irq},
               (k >= 5 && ((k - 5) % 5) == 0) ? 32'd1 : 32'd0);
      end
      rd_now(2'd0, 32'hB, "ar_ctrl_en");
      wr(2'd0, 32'h0, "ar_stop");
      idle(4, "ar_idle");

      // Stop mid-count at COUNT=6, then restart reloads PRESET
      wr(2'd1, 32'd10, "st_pre");
      wr(2'd0, 32'h9, "st_ctrl");
      idle(5, "st_run");
      wr(2'd0, 32'h0, "st_stop");
      for (int k = 0; k < 5; k++) begin
         tick("st_hold");
         check("st_count_hold", bus.rdata, 32'd6);
         check("st_no_irq", {31'b0, bus.irq}, 32'd0);
      end
      wr(2'd0, 32'h9, "st_restart");
      tick("st_r1");
      check("st_count_before_load", bus.rdata, 32'd6);
      tick("st_r2");
      check("st_count_reload", bus.rdata, 32'd10);
      wr(2'd0, 32'h0, "st_off");
      idle(3, "st_idle");

      // PRESET=0, IM=0: pend set silently, then a CTRL write clears it
      wr(2'd1, 32'd0, "p0_pre");
      wr(2'd0, 32'h1, "p0_ctrl");
      for (int k = 0; k < 6; k++) begin
         tick("p0_run");
         check("p0_irq_masked", {31'b0, bus.irq}, 32'd0);
      end
      rd_now(2'd0, 32'h0, "p0_en_dropped");
      wr(2'd0, 32'h8, "p0_unmask");
      for (int k = 0; k < 3; k++) begin
         tick("p0_after");
         check("p0_irq_stays_low", {31'b0, bus.irq}, 32'd0);
      end

      // CTRL write landing on the one-shot expiry edge: written value wins
      wr(2'd1, 32'd2, "co_pre");
      wr(2'd0, 32'h9, "co_ctrl");
      for (int k = 1; k <= 4; k++) tick("co_run");
      check("co_irq_at_int", {31'b0, bus.irq}, 32'd1);
      wr(2'd0, 32'hD, "co_write");
      rd_now(2'd0, 32'hD, "co_ctrl_wins");
      idle(8, "co_after");
      wr(2'd0, 32'h0, "co_off");
      idle(3, "co_idle");

      // Reset asserted at COUNT=2 of a 4-count run
      wr(2'd1, 32'd4, "rs_pre");
      wr(2'd0, 32'h9, "rs_ctrl");
      for (int k = 1; k <= 4; k++) tick("rs_run");
      check("rs_count_before", bus.rdata, 32'd2);
      reset = 1'b0;
      model_reset();
      for (int a = 0; a < 4; a++) rd_now(2'(a), 32'd0, "rs_read_in_reset");
      check("rs_irq_in_reset", {31'b0, bus.irq}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      bus.addr = 2'd2;
      for (int k = 0; k < 10; k++) begin
         tick("rs_after");
         check("rs_no_irq", {31'b0, bus.irq}, 32'd0);
      end
      wr(2'd2, 32'h1234, "rs_wr_count");
      rd_now(2'd2, 32'd0, "rs_count_ro");
      wr(2'd3, 32'hFFFF_FFFF, "rs_wr_rsvd");
      rd_now(2'd3, 32'd0, "rs_rsvd_zero");

      // Randomized bus traffic against the model
      for (int n = 0; n < 600; n++) begin
         int op;
         op = $urandom_range(0, 19);
         case (op)
            0, 1:    drive(1'b1, 1'b1, 2'd0, 32'($urandom_range(0, 15)));
            2:       drive(1'b1, 1'b1, 2'd0, 32'h1 | 32'($urandom_range(0, 15)));
            3:       drive(1'b1, 1'b1, 2'd1, 32'($urandom_range(0, 6)));
            4:       drive(1'b1, 1'b1, 2'($urandom_range(2, 3)), $urandom);
            5:       drive(1'b0, 1'b1, 2'($urandom_range(0, 1)), 32'($urandom_range(0, 15)));
            default: drive(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
         endcase
         if ($urandom_range(0, 149) == 0) begin
            reset = 1'b0;
            model_reset();
            #2 reset = 1'b1;
         end
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
